// File: rtl/vga_pkg.sv
// Shared VGA timing constants, pixel type and colour-bar helpers.
package vga_pkg;

  localparam int unsigned CLK_DIV_DEFAULT = 4;

  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;

  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam int unsigned ROW_OFFSET = V_SYNC + V_BP;
  localparam int unsigned COL_OFFSET = H_SYNC + H_BP;

  localparam int unsigned BAR_WIDTH = 80;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Compare ladder instead of a divide: bar i covers columns [i*80, i*80+79].
  function automatic logic [2:0] bar_index(input logic [9:0] col);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (col >= 10'(i * BAR_WIDTH)) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic rgb444_t bar_colour(input logic [2:0] idx);
    rgb444_t c;
    c.r = {4{idx[2]}};
    c.g = {4{idx[1]}};
    c.b = {4{idx[0]}};
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-side bus between the raster generator and the renderer / display pins.
interface vga_timing_gen_if;
  logic [11:0] d_in;
  logic        pix_tick;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        rdn;
  logic        hs;
  logic        vs;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;

  modport master (
    input  d_in,
    output pix_tick, row_addr, col_addr, rdn, hs, vs, r, g, b
  );

  modport slave (
    output d_in,
    input  pix_tick, row_addr, col_addr, rdn, hs, vs, r, g, b
  );
endinterface

// File: rtl/vga_pix_div.sv
// Free-running board-clock divider producing a registered one-clock pixel strobe.
module vga_pix_div
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic pix_tick
);

  localparam int unsigned DW = $clog2(CLK_DIV);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          pix_tick_q, pix_tick_d;
  logic          div_last;

  always_comb begin
    div_last   = (div_cnt_q == DW'(CLK_DIV - 1));
    div_cnt_d  = div_last ? '0 : div_cnt_q + 1'b1;
    pix_tick_d = div_last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q  <= '0;
      pix_tick_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      pix_tick_q <= pix_tick_d;
    end
  end

  assign pix_tick = pix_tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster generator: h/v counters, address stage, aligned sync/colour stage.
// Define VGA_TEST_PATTERN_EN to ignore d_in and show eight 80-pixel colour bars.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = CLK_DIV_DEFAULT,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOT   = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOT   = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned COL_OFS = H_SYNC + H_BP;
  localparam int unsigned ROW_OFS = V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOT);
  localparam int unsigned VW      = $clog2(V_TOT);

  logic          pix_tick;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [8:0]    row_addr_q, row_addr_d;
  logic [9:0]    col_addr_q, col_addr_d;
  logic          act1_q, act1_d;
  logic          hs1_q, hs1_d;
  logic          vs1_q, vs1_d;
  logic          rdn_q, rdn_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  rgb444_t       rgb_q, rgb_d;
  rgb444_t       pix_src;
  logic          h_act, v_act;

  vga_pix_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
    .clk      (clk),
    .rst      (rst),
    .pix_tick (pix_tick)
  );

`ifdef VGA_TEST_PATTERN_EN
  assign pix_src = bar_colour(bar_index(col_addr_q));
`else
  assign pix_src = rgb444_t'(vga.d_in);
`endif

  // Stage 1 captures the address plus its active/sync flags, so stage 2 only
  // has to delay them by one pixel to line up with the returned colour.
  always_comb begin
    h_act      = (h_cnt_q >= HW'(COL_OFS)) && (h_cnt_q < HW'(COL_OFS + H_ACTIVE));
    v_act      = (v_cnt_q >= VW'(ROW_OFS)) && (v_cnt_q < VW'(ROW_OFS + V_ACTIVE));
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    row_addr_d = row_addr_q;
    col_addr_d = col_addr_q;
    act1_d     = act1_q;
    hs1_d      = hs1_q;
    vs1_d      = vs1_q;
    rdn_d      = rdn_q;
    hs_d       = hs_q;
    vs_d       = vs_q;
    rgb_d      = rgb_q;
    if (pix_tick) begin
      if (h_cnt_q == HW'(H_TOT - 1)) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == VW'(V_TOT - 1)) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
      row_addr_d = 9'(v_cnt_q) - 9'(ROW_OFS);
      col_addr_d = 10'(h_cnt_q) - 10'(COL_OFS);
      act1_d     = h_act && v_act;
      hs1_d      = ~(h_cnt_q < HW'(H_SYNC));
      vs1_d      = ~(v_cnt_q < VW'(V_SYNC));
      rdn_d      = ~act1_q;
      hs_d       = hs1_q;
      vs_d       = vs1_q;
      rgb_d      = act1_q ? pix_src : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      row_addr_q <= '0;
      col_addr_q <= '0;
      act1_q     <= 1'b0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      rdn_q      <= 1'b1;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      rgb_q      <= '0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      row_addr_q <= row_addr_d;
      col_addr_q <= col_addr_d;
      act1_q     <= act1_d;
      hs1_q      <= hs1_d;
      vs1_q      <= vs1_d;
      rdn_q      <= rdn_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      rgb_q      <= rgb_d;
    end
  end

  assign vga.pix_tick = pix_tick;
  assign vga.row_addr = row_addr_q;
  assign vga.col_addr = col_addr_q;
  assign vga.rdn      = rdn_q;
  assign vga.hs       = hs_q;
  assign vga.vs       = vs_q;
  assign vga.r        = rgb_q.r;
  assign vga.g        = rgb_q.g;
  assign vga.b        = rgb_q.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-timing instance for strobe/first-lines/reset, short-frame instance for whole frames.
module tb_vga_timing_gen;

  localparam int unsigned HT      = 800;
  localparam int unsigned COFF    = 144;
  localparam int unsigned BV_SYNC = 2;
  localparam int unsigned BV_BP   = 3;
  localparam int unsigned BV_ACT  = 4;
  localparam int unsigned BV_FP   = 2;
  localparam int unsigned BVT     = BV_SYNC + BV_BP + BV_ACT + BV_FP;
  localparam int unsigned B_ROFF  = BV_SYNC + BV_BP;
  localparam int unsigned BFR     = HT * BVT;
  localparam logic [34:0] RST_OUTS = {1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 9'd0, 10'd0};

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  vga_timing_gen_if if_a();
  vga_timing_gen_if if_b();

  vga_timing_gen #(.CLK_DIV(4)) u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .vga (if_a.master)
  );

  vga_timing_gen #(
    .CLK_DIV  (2),
    .V_SYNC   (BV_SYNC),
    .V_BP     (BV_BP),
    .V_ACTIVE (BV_ACT),
    .V_FP     (BV_FP)
  ) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .vga (if_b.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [34:0] outs_a();
    return {if_a.pix_tick, if_a.rdn, if_a.hs, if_a.vs, if_a.r, if_a.g, if_a.b,
            if_a.row_addr, if_a.col_addr};
  endfunction

  // Returns at the falling edge right after the clock edge that consumed a strobe.
  task automatic wait_tick(input bit use_b);
    bit seen = 1'b0;
    for (int unsigned n = 0; n < 8 && !seen; n++) begin
      @(negedge clk);
      seen = use_b ? if_b.pix_tick : if_a.pix_tick;
    end
    if (!seen) begin
      check("pix_tick_timeout", {63'd0, seen}, 64'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
    @(negedge clk);
  endtask

  // Strobe shape monitor for instance A: period of 4 clocks, never back to back.
  logic a_mon = 1'b0;
  logic a_prev, a_seen;
  int   a_gap, a_consec = 0, a_gap_err = 0;
  always @(negedge clk) begin
    if (!a_mon) begin
      a_prev <= 1'b0;
      a_seen <= 1'b0;
      a_gap  <= 0;
    end else begin
      a_prev <= if_a.pix_tick;
      if (if_a.pix_tick) begin
        if (a_prev) a_consec <= a_consec + 1;
        if (a_seen && a_gap != 3) a_gap_err <= a_gap_err + 1;
        a_seen <= 1'b1;
        a_gap  <= 0;
      end else begin
        a_gap <= a_gap + 1;
      end
    end
  end

  int unsigned n1, n2, h1, v1, h2, v2, bar;
  int unsigned a_hs_low, a_vs_low, a_rdn_low, a_row477;
  int unsigned b_hs_low, b_vs_low, b_rdn_low, b_rdn_low2, b_row511, b_abc, b_blank_nz;
  int unsigned mism1, mism2, vs_fall1, vs_fall2;
  logic        act_e, prev_vs, shown;
  logic [8:0]  row_e;
  logic [9:0]  col_e;
  logic [11:0] din_exp, din_exp_q;
  logic [33:0] exp_v, got_v;

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.d_in = 12'h000;
    if_b.d_in = 12'h000;
    a_hs_low = 0; a_vs_low = 0; a_rdn_low = 0; a_row477 = 0;
    b_hs_low = 0; b_vs_low = 0; b_rdn_low = 0; b_rdn_low2 = 0; b_row511 = 0;
    b_abc = 0; b_blank_nz = 0; mism1 = 0; mism2 = 0; vs_fall1 = 0; vs_fall2 = 0;
    prev_vs = 1'b1; shown = 1'b0; din_exp_q = 12'h000;

    // ---------------- instance A: default timing, CLK_DIV = 4 ----------------
    repeat (3) @(negedge clk);
    check("a_reset_outs", 64'(outs_a()), 64'(RST_OUTS));
    rst_a = 1'b0;
    a_mon = 1'b1;
    for (int unsigned i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("a_tick_clk%0d", i), {63'd0, if_a.pix_tick}, {63'd0, i == 4});
    end
    @(negedge clk);
    for (int unsigned k = 1; k <= 2 * HT + 401; k++) begin
      n1 = k - 1;
      if (k == 1)
        check("a_first_addr", {if_a.rdn, if_a.hs, if_a.vs, if_a.row_addr, if_a.col_addr},
              {1'b1, 1'b1, 1'b1, 9'd477, 10'd880});
      if (k == 2) check("a_first_sync_low", {if_a.hs, if_a.vs}, 2'b00);
      if (n1 == COFF) check("a_col0_at_h144", {if_a.row_addr, if_a.col_addr}, {9'd477, 10'd0});
      if (n1 == HT) check("a_row_line1", if_a.row_addr, 9'd478);
      if (k >= 2 && k <= HT + 1 && !if_a.hs) a_hs_low++;
      if (k >= 2 && k <= 2 * HT + 1) begin
        if (!if_a.vs) a_vs_low++;
        if (!if_a.rdn) a_rdn_low++;
      end
      if (k <= HT && if_a.row_addr == 9'd477) a_row477++;
      if (k < 2 * HT + 401) wait_tick(1'b0);
    end
    check("a_hs_low_line0", a_hs_low, 96);
    check("a_vs_low_2lines", a_vs_low, 1600);
    check("a_rdn_low_blank", a_rdn_low, 0);
    check("a_row477_line0", a_row477, 800);

    // Mid-line asynchronous reset (h = 400, v = 2), checked before the next clock edge.
    a_mon = 1'b0;
    #2 rst_a = 1'b1;
    #1 check("a_async_reset", 64'(outs_a()), 64'(RST_OUTS));
    @(negedge clk);
    rst_a = 1'b0;
    a_mon = 1'b1;
    for (int unsigned i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("a_rst2_tick_clk%0d", i), {63'd0, if_a.pix_tick}, {63'd0, i == 4});
    end
    @(negedge clk);
    check("a_rst2_addr", {if_a.hs, if_a.row_addr, if_a.col_addr}, {1'b1, 9'd477, 10'd880});
    wait_tick(1'b0);
    check("a_rst2_hs_low", if_a.hs, 1'b0);
    a_mon = 1'b0;
    check("a_tick_consecutive", a_consec, 0);
    check("a_tick_period", a_gap_err, 0);

    // ---------------- instance B: short frames, CLK_DIV = 2 ----------------
    @(negedge clk);
    rst_b = 1'b0;
    wait_tick(1'b1);
    for (int unsigned k = 1; k <= 2 * BFR + 2; k++) begin
      n1 = k - 1;
      h1 = n1 % HT;
      v1 = (n1 / HT) % BVT;
      row_e = 9'(v1 + 512 - B_ROFF);
      col_e = 10'(h1 + 1024 - COFF);
      if (k >= 2) begin
        n2 = k - 2;
        h2 = n2 % HT;
        v2 = (n2 / HT) % BVT;
        act_e = (h2 >= COFF) && (h2 < COFF + 640) && (v2 >= B_ROFF) && (v2 < B_ROFF + BV_ACT);
        exp_v = {~act_e, h2 >= 96, v2 >= BV_SYNC, act_e ? din_exp_q : 12'h000, row_e, col_e};
      end else begin
        n2 = 0; h2 = 0; v2 = 0; act_e = 1'b0;
        exp_v = {1'b1, 1'b1, 1'b1, 12'h000, row_e, col_e};
      end
      got_v = {if_b.rdn, if_b.hs, if_b.vs, if_b.r, if_b.g, if_b.b, if_b.row_addr, if_b.col_addr};
      if (got_v !== exp_v) begin
        if (k <= BFR + 1) mism1++; else mism2++;
        if (!shown) begin
          $display("first pixel mismatch at tick %0d: got %0h expected %0h", k, got_v, exp_v);
          shown = 1'b1;
        end
      end

      if (n1 == B_ROFF * HT - 1) check("b_row511_last", if_b.row_addr, 9'd511);
      if (n1 == B_ROFF * HT) check("b_row0_next_line", if_b.row_addr, 9'd0);
      if (k <= BFR && if_b.row_addr == 9'd511) b_row511++;
      if (k >= 2 && n2 == B_ROFF * HT + COFF - 1) check("b_rdn_before_active", if_b.rdn, 1'b1);
      if (k >= 2 && n2 == B_ROFF * HT + COFF) check("b_rdn_first_active", if_b.rdn, 1'b0);
`ifdef VGA_TEST_PATTERN_EN
      if (k >= 2 && n2 >= BFR && v2 == B_ROFF && h2 == COFF + 85)
        check("b_bar_col85", {if_b.r, if_b.g, if_b.b}, 12'h00F);
      if (k >= 2 && n2 >= BFR && v2 == B_ROFF && h2 == COFF + 600)
        check("b_bar_col600", {if_b.r, if_b.g, if_b.b}, 12'hFFF);
`else
      if (k >= 2 && n2 == BFR + B_ROFF * HT + COFF)
        check("b_abc_first_active", {if_b.r, if_b.g, if_b.b}, 12'hABC);
      if (k >= BFR + 2 && k <= 2 * BFR + 1 && !if_b.rdn && {if_b.r, if_b.g, if_b.b} == 12'hABC)
        b_abc++;
`endif
      if (k >= 2 && k <= BFR + 1) begin
        if (!if_b.hs) b_hs_low++;
        if (!if_b.vs) b_vs_low++;
        if (!if_b.rdn) b_rdn_low++;
      end
      if (k >= BFR + 2 && k <= 2 * BFR + 1 && !if_b.rdn) b_rdn_low2++;
      if (if_b.rdn && {if_b.r, if_b.g, if_b.b} != 12'h000) b_blank_nz++;
      if (prev_vs && !if_b.vs) begin
        if (vs_fall1 == 0) vs_fall1 = k; else if (vs_fall2 == 0) vs_fall2 = k;
      end
      prev_vs = if_b.vs;

      // Renderer: frame 1 returns an address-derived colour, frame 2 a constant.
      if (n1 < BFR) begin
        if_b.d_in = {if_b.col_addr[3:0], if_b.row_addr[3:0], 4'h0};
        din_exp   = {col_e[3:0], row_e[3:0], 4'h0};
      end else begin
        if_b.d_in = 12'hABC;
        din_exp   = 12'hABC;
      end
`ifdef VGA_TEST_PATTERN_EN
      bar = 32'(col_e) / 80;
      din_exp = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
`endif
      din_exp_q = din_exp;
      if (k < 2 * BFR + 2) wait_tick(1'b1);
    end

    check("b_pixel_model_frame1", mism1, 0);
    check("b_pixel_model_frame2", mism2, 0);
    check("b_hs_low_frame", b_hs_low, 96 * BVT);
    check("b_vs_low_frame", b_vs_low, BV_SYNC * HT);
    check("b_rdn_low_frame1", b_rdn_low, 640 * BV_ACT);
    check("b_rdn_low_frame2", b_rdn_low2, 640 * BV_ACT);
    check("b_row511_count", b_row511, HT);
    check("b_blank_rgb_nonzero", b_blank_nz, 0);
    check("b_frame_length", vs_fall2 - vs_fall1, BFR);
`ifndef VGA_TEST_PATTERN_EN
    check("b_abc_pixels", b_abc, 640 * BV_ACT);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
